fp_div_operand_unpack: RTL and testbench

Upstream front-end for fp_divider. Accepts raw packed IEEE-754 operands (binary32 or binary16) over a valid/ready handshake and unpacks them into the sign/exponent/mantissa fields fp_divider consumes. Rebiases half-precision operands to the binary32 bias and normalizes half subnormals iteratively. Resolves IEEE special cases (NaN, Inf, zero) itself and issues start to the divider only for finite non-zero operand pairs.

---
 rtl/fp_div_operand_unpack.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_fp_div_operand_unpack.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_operand_unpack.sv
// Front-end for fp_divider: unpacks binary32/binary16 operand pairs, rebiases and
// normalizes half subnormals, resolves IEEE special cases and issues divider starts.
module fp_div_operand_unpack #(
  parameter int unsigned SP_EXP_BIAS    = 127,
  parameter int unsigned HP_EXP_BIAS    = 15,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mode_fp,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        div_ready,
  output logic        div_start,
  output logic        mode_fp,
  output logic        sign_a,
  output logic        sign_b,
  output logic [7:0]  exp_a,
  output logic [7:0]  exp_b,
  output logic [22:0] mant_a,
  output logic [22:0] mant_b,
  output logic        special_valid,
  output logic [31:0] special_result,
  output logic        invalid,
  output logic        div_by_zero,
  output logic        denorm_flush,
  output logic        div_timeout
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CLASSIFY  = 3'd1;
  localparam logic [2:0] S_NORM_A    = 3'd2;
  localparam logic [2:0] S_NORM_B    = 3'd3;
  localparam logic [2:0] S_ISSUE     = 3'd4;
  localparam logic [2:0] S_WAIT_ACK  = 3'd5;
  localparam logic [2:0] S_WAIT_DONE = 3'd6;
  localparam logic [2:0] S_SPECIAL   = 3'd7;

  localparam logic [1:0] K_ZERO = 2'd0;
  localparam logic [1:0] K_INF  = 2'd1;
  localparam logic [1:0] K_QNAN = 2'd2;

  localparam logic [7:0]    EXP_OFS  = 8'(SP_EXP_BIAS - HP_EXP_BIAS);
  localparam int unsigned   CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
    logic        zero;
    logic        inf;
    logic        nan;
    logic        snan;
    logic        flush;
    logic        hsub;
  } opnd_t;

  // Binary32 subnormals are folded into zero; half subnormals start at the
  // smallest normal exponent and are shifted up later.
  function automatic opnd_t decode(input logic [31:0] raw, input logic fp);
    opnd_t o;
    logic  emax;
    o = '0;
    if (fp) begin
      o.sign  = raw[31];
      o.exp   = raw[30:23];
      o.frac  = raw[22:0];
      emax    = &raw[30:23];
      o.zero  = (raw[30:23] == '0);
      o.flush = o.zero && (raw[22:0] != '0);
    end else begin
      o.sign = raw[15];
      o.frac = {raw[9:0], 13'b0};
      emax   = &raw[14:10];
      o.hsub = (raw[14:10] == '0) && (raw[9:0] != '0);
      o.zero = (raw[14:10] == '0) && (raw[9:0] == '0);
      o.exp  = o.hsub ? EXP_OFS + 8'd1 : {3'b0, raw[14:10]} + EXP_OFS;
    end
    o.inf  = emax && (o.frac == '0);
    o.nan  = emax && (o.frac != '0);
    o.snan = o.nan && !o.frac[22];
    return o;
  endfunction

  function automatic logic [31:0] encode(input logic [1:0] kind, input logic s, input logic fp);
    logic [31:0] r;
    if (fp) begin
      case (kind)
        K_ZERO:  r = {s, 31'b0};
        K_INF:   r = {s, 8'hFF, 23'b0};
        default: r = 32'h7FC0_0000;
      endcase
    end else begin
      case (kind)
        K_ZERO:  r = {16'b0, s, 15'b0};
        K_INF:   r = {16'b0, s, 5'h1F, 10'b0};
        default: r = 32'h0000_7E00;
      endcase
    end
    return r;
  endfunction

  logic [2:0]    state_q, state_d;
  logic [31:0]   op_a_q, op_a_d, op_b_q, op_b_d;
  logic          mode_q, mode_d;
  logic          sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [7:0]    exp_a_q, exp_a_d, exp_b_q, exp_b_d;
  logic [22:0]   mant_a_q, mant_a_d, mant_b_q, mant_b_d;
  logic [10:0]   sig_a_q, sig_a_d, sig_b_q, sig_b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          div_start_q, div_start_d;
  logic          special_valid_q, special_valid_d;
  logic [31:0]   special_result_q, special_result_d;
  logic          invalid_q, invalid_d;
  logic          div_by_zero_q, div_by_zero_d;
  logic          denorm_flush_q, denorm_flush_d;
  logic          div_timeout_q, div_timeout_d;

  opnd_t      dec_a, dec_b;
  logic       spec_hit, spec_inv, spec_dbz;
  logic [1:0] spec_kind;

  always_comb begin
    dec_a = decode(op_a_q, mode_q);
    dec_b = decode(op_b_q, mode_q);
  end

  // First matching rule wins; the ordering encodes IEEE precedence.
  always_comb begin
    spec_hit  = 1'b1;
    spec_inv  = 1'b0;
    spec_dbz  = 1'b0;
    spec_kind = K_QNAN;
    if (dec_a.nan || dec_b.nan) begin
      spec_inv = dec_a.snan || dec_b.snan;
    end else if ((dec_a.zero && dec_b.zero) || (dec_a.inf && dec_b.inf)) begin
      spec_inv = 1'b1;
    end else if (dec_a.inf) begin
      spec_kind = K_INF;
    end else if (dec_b.inf) begin
      spec_kind = K_ZERO;
    end else if (dec_b.zero) begin
      spec_kind = K_INF;
      spec_dbz  = 1'b1;
    end else if (dec_a.zero) begin
      spec_kind = K_ZERO;
    end else begin
      spec_hit = 1'b0;
    end
  end

  always_comb begin
    state_d          = state_q;
    op_a_d           = op_a_q;
    op_b_d           = op_b_q;
    mode_d           = mode_q;
    sign_a_d         = sign_a_q;
    sign_b_d         = sign_b_q;
    exp_a_d          = exp_a_q;
    exp_b_d          = exp_b_q;
    mant_a_d         = mant_a_q;
    mant_b_d         = mant_b_q;
    sig_a_d          = sig_a_q;
    sig_b_d          = sig_b_q;
    cnt_d            = '0;
    div_start_d      = 1'b0;
    special_valid_d  = 1'b0;
    special_result_d = special_result_q;
    invalid_d        = invalid_q;
    div_by_zero_d    = div_by_zero_q;
    denorm_flush_d   = denorm_flush_q;
    div_timeout_d    = div_timeout_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_a_d           = op_a;
          op_b_d           = op_b;
          mode_d           = in_mode_fp;
          special_result_d = '0;
          invalid_d        = 1'b0;
          div_by_zero_d    = 1'b0;
          denorm_flush_d   = 1'b0;
          state_d          = S_CLASSIFY;
        end
      end
      S_CLASSIFY: begin
        sign_a_d       = dec_a.sign;
        sign_b_d       = dec_b.sign;
        exp_a_d        = dec_a.exp;
        exp_b_d        = dec_b.exp;
        mant_a_d       = dec_a.frac;
        mant_b_d       = dec_b.frac;
        sig_a_d        = {!dec_a.hsub, dec_a.frac[22:13]};
        sig_b_d        = {!dec_b.hsub, dec_b.frac[22:13]};
        denorm_flush_d = dec_a.flush || dec_b.flush;
        if (spec_hit) begin
          special_result_d = encode(spec_kind, dec_a.sign ^ dec_b.sign, mode_q);
          invalid_d        = spec_inv;
          div_by_zero_d    = spec_dbz;
          special_valid_d  = 1'b1;
          state_d          = S_SPECIAL;
        end else if (dec_a.hsub) begin
          state_d = S_NORM_A;
        end else if (dec_b.hsub) begin
          state_d = S_NORM_B;
        end else begin
          state_d = S_ISSUE;
        end
      end
      // Exit is decided on the pre-shift bit 9, i.e. the bit that lands in bit 10.
      S_NORM_A: begin
        sig_a_d  = {sig_a_q[9:0], 1'b0};
        exp_a_d  = exp_a_q - 8'd1;
        mant_a_d = {sig_a_q[8:0], 14'b0};
        if (sig_a_q[9]) state_d = sig_b_q[10] ? S_ISSUE : S_NORM_B;
      end
      S_NORM_B: begin
        sig_b_d  = {sig_b_q[9:0], 1'b0};
        exp_b_d  = exp_b_q - 8'd1;
        mant_b_d = {sig_b_q[8:0], 14'b0};
        if (sig_b_q[9]) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (div_ready) begin
          div_start_d = 1'b1;
          state_d     = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK:  if (!div_ready) state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (div_ready) state_d = S_IDLE;
      S_SPECIAL:   state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    // The counter restarts on every entry into a wait state because it defaults to zero.
    if ((state_q == S_ISSUE || state_q == S_WAIT_ACK || state_q == S_WAIT_DONE) &&
        state_d == state_q) begin
      if (cnt_q == CNT_LAST) begin
        div_timeout_d = 1'b1;
        state_d       = S_IDLE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      op_a_q           <= '0;
      op_b_q           <= '0;
      mode_q           <= 1'b0;
      sign_a_q         <= 1'b0;
      sign_b_q         <= 1'b0;
      exp_a_q          <= '0;
      exp_b_q          <= '0;
      mant_a_q         <= '0;
      mant_b_q         <= '0;
      sig_a_q          <= '0;
      sig_b_q          <= '0;
      cnt_q            <= '0;
      div_start_q      <= 1'b0;
      special_valid_q  <= 1'b0;
      special_result_q <= '0;
      invalid_q        <= 1'b0;
      div_by_zero_q    <= 1'b0;
      denorm_flush_q   <= 1'b0;
      div_timeout_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      op_a_q           <= op_a_d;
      op_b_q           <= op_b_d;
      mode_q           <= mode_d;
      sign_a_q         <= sign_a_d;
      sign_b_q         <= sign_b_d;
      exp_a_q          <= exp_a_d;
      exp_b_q          <= exp_b_d;
      mant_a_q         <= mant_a_d;
      mant_b_q         <= mant_b_d;
      sig_a_q          <= sig_a_d;
      sig_b_q          <= sig_b_d;
      cnt_q            <= cnt_d;
      div_start_q      <= div_start_d;
      special_valid_q  <= special_valid_d;
      special_result_q <= special_result_d;
      invalid_q        <= invalid_d;
      div_by_zero_q    <= div_by_zero_d;
      denorm_flush_q   <= denorm_flush_d;
      div_timeout_q    <= div_timeout_d;
    end
  end

  assign in_ready       = (state_q == S_IDLE);
  assign div_start      = div_start_q;
  assign mode_fp        = mode_q;
  assign sign_a         = sign_a_q;
  assign sign_b         = sign_b_q;
  assign exp_a          = exp_a_q;
  assign exp_b          = exp_b_q;
  assign mant_a         = mant_a_q;
  assign mant_b         = mant_b_q;
  assign special_valid  = special_valid_q;
  assign special_result = special_result_q;
  assign invalid        = invalid_q;
  assign div_by_zero    = div_by_zero_q;
  assign denorm_flush   = denorm_flush_q;
  assign div_timeout    = div_timeout_q;

endmodule

// File: tb/tb_fp_div_operand_unpack.sv
// Directed bench for fp_div_operand_unpack: normal issue timing, half subnormal
// normalization, special-case resolution, divider timeout and mid-operation reset.
module tb_fp_div_operand_unpack;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_mode_fp;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        div_ready;
  logic        div_start;
  logic        mode_fp;
  logic        sign_a;
  logic        sign_b;
  logic [7:0]  exp_a;
  logic [7:0]  exp_b;
  logic [22:0] mant_a;
  logic [22:0] mant_b;
  logic        special_valid;
  logic [31:0] special_result;
  logic        invalid;
  logic        div_by_zero;
  logic        denorm_flush;
  logic        div_timeout;

  int checks   = 0;
  int failures = 0;

  fp_div_operand_unpack #(
    .SP_EXP_BIAS   (127),
    .HP_EXP_BIAS   (15),
    .TIMEOUT_CYCLES(255)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_mode_fp    (in_mode_fp),
    .op_a          (op_a),
    .op_b          (op_b),
    .div_ready     (div_ready),
    .div_start     (div_start),
    .mode_fp       (mode_fp),
    .sign_a        (sign_a),
    .sign_b        (sign_b),
    .exp_a         (exp_a),
    .exp_b         (exp_b),
    .mant_a        (mant_a),
    .mant_b        (mant_b),
    .special_valid (special_valid),
    .special_result(special_result),
    .invalid       (invalid),
    .div_by_zero   (div_by_zero),
    .denorm_flush  (denorm_flush),
    .div_timeout   (div_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept one pair, wait for div_start, check fields, then complete the handshake.
  task automatic do_normal(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic m, input int lat,
                           input logic sa, input logic [7:0] ea, input logic [22:0] ma,
                           input logic sb, input logic [7:0] eb, input logic [22:0] mb);
    int n;
    logic sv_seen;
    op_a = a; op_b = b; in_mode_fp = m; in_valid = 1'b1; div_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, "_in_ready_low"}, in_ready, 1'b0);
    n = 0;
    sv_seen = 1'b0;
    while (n < 40) begin
      step();
      n++;
      if (special_valid) sv_seen = 1'b1;
      if (div_start) break;
    end
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_no_special"}, sv_seen, 1'b0);
    chk({tag, "_mode_fp"}, mode_fp, m);
    chk({tag, "_sign_a"}, sign_a, sa);
    chk({tag, "_exp_a"}, exp_a, ea);
    chk({tag, "_mant_a"}, mant_a, ma);
    chk({tag, "_sign_b"}, sign_b, sb);
    chk({tag, "_exp_b"}, exp_b, eb);
    chk({tag, "_mant_b"}, mant_b, mb);
    step();
    chk({tag, "_start_pulse"}, div_start, 1'b0);
    div_ready = 1'b0;
    step();
    chk({tag, "_busy_wait_done"}, in_ready, 1'b0);
    chk({tag, "_exp_a_stable"}, exp_a, ea);
    div_ready = 1'b1;
    step();
    chk({tag, "_in_ready_back"}, in_ready, 1'b1);
  endtask

  task automatic do_special(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic m, input logic [31:0] res,
                            input logic inv, input logic dbz, input logic fl);
    int n;
    logic started;
    op_a = a; op_b = b; in_mode_fp = m; in_valid = 1'b1; div_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    started = 1'b0;
    while (n < 10) begin
      step();
      n++;
      if (div_start) started = 1'b1;
      if (special_valid) break;
    end
    chk({tag, "_latency"}, n, 1);
    chk({tag, "_result"}, special_result, res);
    chk({tag, "_invalid"}, invalid, inv);
    chk({tag, "_div_by_zero"}, div_by_zero, dbz);
    chk({tag, "_denorm_flush"}, denorm_flush, fl);
    step();
    if (div_start) started = 1'b1;
    chk({tag, "_pulse_one_cycle"}, special_valid, 1'b0);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_no_div_start"}, started, 1'b0);
  endtask

  initial begin
    int   n;
    logic bad;
    rst = 1'b1; in_valid = 1'b0; in_mode_fp = 1'b0; op_a = '0; op_b = '0; div_ready = 1'b0;
    step();
    step();
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_div_start", div_start, 1'b0);
    chk("reset_special_valid", special_valid, 1'b0);
    chk("reset_special_result", special_result, 32'h0);
    chk("reset_div_timeout", div_timeout, 1'b0);
    chk("reset_exp_a", exp_a, 8'h00);
    chk("reset_mode_fp", mode_fp, 1'b0);
    rst = 1'b0;
    step();

    do_normal("sp_1_over_2", 32'h3F80_0000, 32'h4000_0000, 1'b1, 2,
              1'b0, 8'd127, 23'h0, 1'b0, 8'd128, 23'h0);
    do_normal("sp_negpi_over_half", 32'hC049_0FDB, 32'h3F00_0000, 1'b1, 2,
              1'b1, 8'h80, 23'h49_0FDB, 1'b0, 8'h7E, 23'h0);
    do_normal("hp_min_sub_a", 32'h0000_0001, 32'h0000_3C00, 1'b0, 12,
              1'b0, 8'd103, 23'h0, 1'b0, 8'd127, 23'h0);
    do_normal("hp_sub_b_one_shift", 32'h0000_BE00, 32'h0000_0200, 1'b0, 3,
              1'b1, 8'd127, 23'h40_0000, 1'b0, 8'd112, 23'h0);

    do_special("sp_x_over_negzero", 32'h3F80_0000, 32'h8000_0000, 1'b1, 32'hFF80_0000, 1'b0, 1'b1, 1'b0);
    do_special("sp_zero_over_zero", 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h7FC0_0000, 1'b1, 1'b0, 1'b0);
    do_special("hp_inf_over_inf", 32'h0000_7C00, 32'h0000_7C00, 1'b0, 32'h0000_7E00, 1'b1, 1'b0, 1'b0);
    do_special("sp_snan_a", 32'h7F80_0001, 32'h3F80_0000, 1'b1, 32'h7FC0_0000, 1'b1, 1'b0, 1'b0);
    do_special("sp_qnan_a", 32'h7FC0_0000, 32'h3F80_0000, 1'b1, 32'h7FC0_0000, 1'b0, 1'b0, 1'b0);
    do_special("hp_snan_a", 32'h0000_7D00, 32'h0000_3C00, 1'b0, 32'h0000_7E00, 1'b1, 1'b0, 1'b0);
    do_special("sp_denorm_flush", 32'h0000_0001, 32'h3F80_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    do_special("hp_neginf_over_x", 32'h0000_FC00, 32'h0000_3C00, 1'b0, 32'h0000_FC00, 1'b0, 1'b0, 1'b0);
    do_special("sp_x_over_neginf", 32'h3F80_0000, 32'hFF80_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    do_special("sp_negzero_over_x", 32'h8000_0000, 32'h3F80_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    do_special("hp_negx_over_zero", 32'h0000_BC00, 32'h0000_0000, 1'b0, 32'h0000_FC00, 1'b0, 1'b1, 1'b0);
    do_special("sp_inf_over_zero", 32'h7F80_0000, 32'h0000_0000, 1'b1, 32'h7F80_0000, 1'b0, 1'b0, 1'b0);
    do_special("sp_zero_over_inf", 32'h0000_0000, 32'h7F80_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0);

    // Divider never acknowledges: div_ready stays high through WAIT_ACK.
    op_a = 32'h3F80_0000; op_b = 32'h4000_0000; in_mode_fp = 1'b1; in_valid = 1'b1; div_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (n < 10) begin
      step();
      n++;
      if (div_start) break;
    end
    chk("timeout_issue_latency", n, 2);
    repeat (254) step();
    chk("timeout_not_yet", div_timeout, 1'b0);
    chk("timeout_still_busy", in_ready, 1'b0);
    step();
    chk("timeout_flag", div_timeout, 1'b1);
    chk("timeout_in_ready", in_ready, 1'b1);
    chk("timeout_div_start", div_start, 1'b0);
    step();
    chk("timeout_sticky", div_timeout, 1'b1);

    // Reset while normalizing a half subnormal must abort without any pulse.
    op_a = 32'h0000_0001; op_b = 32'h0000_3C00; in_mode_fp = 1'b0; in_valid = 1'b1; div_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("midnorm_busy", in_ready, 1'b0);
    rst = 1'b1;
    step();
    chk("midnorm_rst_in_ready", in_ready, 1'b1);
    chk("midnorm_rst_div_start", div_start, 1'b0);
    chk("midnorm_rst_special_valid", special_valid, 1'b0);
    chk("midnorm_rst_clears_timeout", div_timeout, 1'b0);
    rst = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      step();
      if (div_start || special_valid || !in_ready) bad = 1'b1;
    end
    chk("midnorm_no_pulse_after", bad, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
